// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS-32 inter-stage pipeline registers.
// Holds stage widths, control-bit positions, the bubble encoding and the buffer state type.
package mips_pipe_pkg;

    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned ID_EX_DATA_W  = 138;
    localparam int unsigned ID_EX_CTRL_W  = 9;
    localparam int unsigned EX_MEM_DATA_W = 102;
    localparam int unsigned EX_MEM_CTRL_W = 5;
    localparam int unsigned MEM_WB_DATA_W = 69;
    localparam int unsigned MEM_WB_CTRL_W = 2;

    // ID/EX control bit positions, MSB first: RegDst .. ALUOp
    localparam int unsigned CTRL_REGDST    = 8;
    localparam int unsigned CTRL_BRANCH    = 7;
    localparam int unsigned CTRL_MEMREAD   = 6;
    localparam int unsigned CTRL_MEMTOREG  = 5;
    localparam int unsigned CTRL_MEMWRITE  = 4;
    localparam int unsigned CTRL_ALUSRC    = 3;
    localparam int unsigned CTRL_REGWRITE  = 2;
    localparam int unsigned CTRL_ALUOP_MSB = 1;
    localparam int unsigned CTRL_ALUOP_LSB = 0;

    localparam logic [ID_EX_CTRL_W-1:0] ID_EX_CTRL_NOP = '0;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    // Encoding mirrors {main_valid, skid_valid}; 2'b01 is unreachable
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// One pipeline entry: valid flag, payload and control with load / clear / hold.
// Clearing drops valid and forces control to the bubble value; payload is left stale.
module pipe_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = ID_EX_DATA_W,
    parameter int unsigned       CTRL_W   = ID_EX_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(ID_EX_CTRL_NOP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= CTRL_NOP;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_ctrl  <= CTRL_NOP;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid.
// Supports flush (bubble insertion) and a saturating stall-cycle counter.
module pipe_stage_buffer
    import mips_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = ID_EX_DATA_W,
    parameter int unsigned       CTRL_W   = ID_EX_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(ID_EX_CTRL_NOP),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    buf_state_e        state;
    buf_state_e        next_state;
    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              emit;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;

    // State lives in the two entry valid flags
    assign state     = buf_state_e'({main_valid, skid_valid});
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign emit      = main_valid & out_ready;

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_FULL;
            ST_FULL: begin
                if (emit && !accept)            next_state = ST_EMPTY;
                else if (accept && !out_ready)  next_state = ST_SKID;
            end
            ST_SKID:  if (out_ready) next_state = ST_FULL;
            default:  next_state = ST_EMPTY;
        endcase
        if (flush) next_state = ST_EMPTY;
    end

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state)
            ST_EMPTY: main_load = accept;
            ST_FULL: begin
                if (emit) begin
                    main_load  = accept;
                    main_clear = !accept;
                end else begin
                    skid_load  = accept;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end
            end
            default: begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end
        endcase
        // Flush wins over every handshake and kills both entries
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    pipe_skid_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .d_data  (main_from_skid ? skid_data : in_data),
        .d_ctrl  (main_from_skid ? skid_ctrl : in_ctrl),
        .q_valid (main_valid),
        .q_data  (out_data),
        .q_ctrl  (out_ctrl)
    );

    pipe_skid_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready <= 1'b1;
        else        in_ready <= (next_state != ST_SKID);
    end

    // Saturating stall counter; clear beats increment, flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed and random checks of pipe_stage_buffer against a queue scoreboard.
// A second instance with a 4-bit stall counter shares the stimulus for saturation checks.
module tb_pipe_stage_buffer;

    localparam int unsigned DATA_W = 138;
    localparam int unsigned CTRL_W = 9;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_ready;
    logic              clr_cnt;

    logic              u0_in_ready, u1_in_ready;
    logic              u0_out_valid, u1_out_valid;
    logic [DATA_W-1:0] u0_out_data, u1_out_data;
    logic [CTRL_W-1:0] u0_out_ctrl, u1_out_ctrl;
    logic [15:0]       u0_stall_cnt;
    logic [3:0]        u1_stall_cnt;

    int          n_checks;
    int          n_err;
    int unsigned seq;
    ent_t        q[$];
    logic [15:0] exp16;
    logic [3:0]  exp4;

    pipe_stage_buffer u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(u0_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(u0_out_valid), .out_ready(out_ready), .out_data(u0_out_data),
        .out_ctrl(u0_out_ctrl), .clr_cnt(clr_cnt), .stall_cnt(u0_stall_cnt)
    );

    pipe_stage_buffer #(.CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(u1_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(u1_out_valid), .out_ready(out_ready), .out_data(u1_out_data),
        .out_ctrl(u1_out_ctrl), .clr_cnt(clr_cnt), .stall_cnt(u1_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(input int unsigned s);
        ent_t e;
        e.d = {s, ~s, s ^ 32'hA5A5_5A5A, ~s ^ 32'h1234_5678, 10'(s)};
        e.c = 9'(s) | 9'h001;
        return e;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 256'(u0_out_valid), 256'(q.size() > 0));
        check("in_ready", 256'(u0_in_ready), 256'(q.size() < 2));
        check("u1_out_valid", 256'(u1_out_valid), 256'(q.size() > 0));
        check("u1_in_ready", 256'(u1_in_ready), 256'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_data", 256'(u0_out_data), 256'(q[0].d));
            check("out_ctrl", 256'(u0_out_ctrl), 256'(q[0].c));
            check("u1_out_data", 256'(u1_out_data), 256'(q[0].d));
        end else begin
            check("out_ctrl_nop", 256'(u0_out_ctrl), 256'(0));
            check("u1_out_ctrl_nop", 256'(u1_out_ctrl), 256'(0));
        end
        check("stall_cnt", 256'(u0_stall_cnt), 256'(exp16));
        check("stall_cnt4", 256'(u1_stall_cnt), 256'(exp4));
    endtask

    // Drive one cycle, advance the scoreboard across the edge, then check
    task automatic cycle(input logic v, input logic r, input logic fl, input logic clr);
        ent_t e;
        logic acc, emt, stl;
        e = mk(seq);
        in_valid = v; out_ready = r; flush = fl; clr_cnt = clr;
        in_data = e.d; in_ctrl = e.c;
        acc = v && (q.size() < 2);
        emt = (q.size() > 0) && r;
        stl = (q.size() > 0) && !r;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (acc) seq++;
        if (clr)                          exp16 = '0;
        else if (stl && exp16 != 16'hFFFF) exp16 = exp16 + 16'd1;
        if (clr)                          exp4 = '0;
        else if (stl && exp4 != 4'hF)     exp4 = exp4 + 4'd1;
        check_outputs();
    endtask

    task automatic reset_mid_stream();
        #3;
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        q.delete();
        exp16 = '0;
        exp4  = '0;
        check("rst_out_valid", 256'(u0_out_valid), 256'(0));
        check("rst_out_ctrl", 256'(u0_out_ctrl), 256'(0));
        check("rst_in_ready", 256'(u0_in_ready), 256'(1));
        check("rst_stall_cnt", 256'(u0_stall_cnt), 256'(0));
        check("rst_stall_cnt4", 256'(u1_stall_cnt), 256'(0));
        @(posedge clk);
        #1;
        check("rst_edge_out_valid", 256'(u0_out_valid), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned base;
        n_checks = 0; n_err = 0; seq = 1;
        exp16 = '0; exp4 = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        in_data = '0; in_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        check("init_out_valid", 256'(u0_out_valid), 256'(0));
        check("init_out_data", 256'(u0_out_data), 256'(0));
        check("init_in_ready", 256'(u0_in_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Stream: 8 back-to-back, one-cycle latency, no gaps
        base = seq;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            check("stream_valid", 256'(u0_out_valid), 256'(1));
            check("stream_data", 256'(u0_out_data), 256'(mk(base + 32'(k)).d));
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("stream_drain", 256'(u0_out_valid), 256'(0));

        // Stall: fill then 5 stalled cycles, then release
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        base = seq;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_ready1", 256'(u0_in_ready), 256'(1));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_ready2", 256'(u0_in_ready), 256'(0));
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_cnt5", 256'(u0_stall_cnt), 256'(5));
        check("stall_hold", 256'(u0_out_data), 256'(mk(base).d));
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("release_2nd", 256'(u0_out_data), 256'(mk(base + 1).d));
        check("release_ready", 256'(u0_in_ready), 256'(1));
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("release_empty", 256'(u0_out_valid), 256'(0));

        // Flush while SKID with a live input
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_flush_ready", 256'(u0_in_ready), 256'(0));
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_valid", 256'(u0_out_valid), 256'(0));
        check("flush_ctrl", 256'(u0_out_ctrl), 256'(0));
        check("flush_ready", 256'(u0_in_ready), 256'(1));
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_dropped", 256'(u0_out_valid), 256'(0));

        // Saturation of the 4-bit counter, then clear during stall
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_cnt4", 256'(u1_stall_cnt), 256'(15));
        check("sat_cnt16", 256'(u0_stall_cnt), 256'(20));
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_cnt4", 256'(u1_stall_cnt), 256'(0));
        check("clr_cnt16", 256'(u0_stall_cnt), 256'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_clr_cnt", 256'(u0_stall_cnt), 256'(1));
        cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream with entries held
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        reset_mid_stream();

        // Random valid/ready/flush/clear against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0,
                  ($urandom % 64) == 0, ($urandom % 128) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
